weight_write_controller: RTL

WEIGHT_WRITE_CONTROLLER -- requirements
Module: weight_write_controller

---
 rtl/weight_write_controller.sv | 106 ++++++++++
 1 files changed

// File: rtl/weight_write_controller.sv
// Packs four IN_WIDTH weight words into one double-buffer word, writes one weight tile per bank,
// and swaps banks once the tile is complete and the reader has released the other bank.
module weight_write_controller #(
    parameter int unsigned IN_WIDTH        = 16,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned BANK_ADDR_WIDTH = 10,
    parameter int unsigned BANK_DEPTH      = 288
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [IN_WIDTH-1:0]        in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       reader_done,
    output logic                       wen,
    output logic [BANK_ADDR_WIDTH-1:0] wadr,
    output logic [DATA_WIDTH-1:0]      wdata,
    output logic                       switch_banks
);

    localparam int unsigned LANES      = 4;
    localparam int unsigned PACK_WIDTH = (LANES - 1) * IN_WIDTH;
    localparam logic [BANK_ADDR_WIDTH-1:0] LAST_ADDR = BANK_ADDR_WIDTH'(BANK_DEPTH - 1);

    typedef enum logic [1:0] {
        FILL        = 2'd0,
        WAIT_SWITCH = 2'd1,
        SWITCH      = 2'd2
    } state_t;

    state_t                     state;
    logic [1:0]                 lane;
    logic [BANK_ADDR_WIDTH-1:0] addr;
    logic [PACK_WIDTH-1:0]      pack;
    logic                       can_switch;
    logic                       accept_c;

    assign accept_c = in_valid && in_ready;

    // Lanes 0..2 are staged in pack; lane 3 goes straight into wdata with the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FILL;
            lane         <= 2'd0;
            addr         <= '0;
            pack         <= '0;
            can_switch   <= 1'b1;
            in_ready     <= 1'b1;
            wen          <= 1'b0;
            wadr         <= '0;
            wdata        <= '0;
            switch_banks <= 1'b0;
        end else begin
            wen          <= 1'b0;
            switch_banks <= 1'b0;
            if (reader_done) begin
                can_switch <= 1'b1;
            end

            case (state)
                FILL: begin
                    if (accept_c) begin
                        lane <= lane + 2'd1;
                        for (int k = 0; k < int'(LANES - 1); k++) begin
                            if (lane == 2'(k)) begin
                                pack[k*IN_WIDTH +: IN_WIDTH] <= in_data;
                            end
                        end
                        if (lane == 2'd3) begin
                            wen   <= 1'b1;
                            wadr  <= addr;
                            wdata <= DATA_WIDTH'({in_data, pack});
                            addr  <= addr + BANK_ADDR_WIDTH'(1);
                            if (addr == LAST_ADDR) begin
                                state    <= WAIT_SWITCH;
                                in_ready <= 1'b0;
                            end
                        end
                    end
                end

                WAIT_SWITCH: begin
                    if (can_switch || reader_done) begin
                        state        <= SWITCH;
                        switch_banks <= 1'b1;
                    end
                end

                SWITCH: begin
                    // A reader_done landing on the swap cycle must survive the clear.
                    can_switch <= reader_done;
                    addr       <= '0;
                    lane       <= 2'd0;
                    state      <= FILL;
                    in_ready   <= 1'b1;
                end

                default: begin
                    state    <= FILL;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
